// File: rtl/mem_seq_pkg.sv
// Shared definitions for the capture-memory read sequencer:
// FSM states and the memory command bus encodings.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } seqState_t;

  // MemCmd bit positions
  localparam int unsigned CMD_SELP  = 0;
  localparam int unsigned CMD_PATHN = 1;
  localparam int unsigned CMD_RD    = 2;
  localparam int unsigned CMD_SELN  = 3;

  localparam logic [3:0] CMD_IDLE    = 4'b0000;
  localparam logic [3:0] CMD_ISSUE_P = 4'b0101;
  localparam logic [3:0] CMD_ISSUE_N = 4'b1110;
  localparam logic [3:0] CMD_WAIT_P  = 4'b0001;
  localparam logic [3:0] CMD_WAIT_N  = 4'b1010;

endpackage

// File: rtl/mem_read_sequencer_if.sv
// Requester and memory-side signals of the read sequencer.
// master = the sequencer itself, slave = requesters plus memory manager.
interface mem_read_sequencer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              ReqP;
    logic [ADDR_W-1:0] AddrP;
    logic              ReqN;
    logic [ADDR_W-1:0] AddrN;
    logic              GntP;
    logic              GntN;
    logic [3:0]        MemCmd;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic [31:0]       MemData;
    logic [31:0]       RdData;
    logic              RdValid;
    logic              RdSrc;
    logic              RdErr;

    modport master (
        input  ReqP, AddrP, ReqN, AddrN, MemAck, MemData,
        output GntP, GntN, MemCmd, MemAddr, RdData, RdValid, RdSrc, RdErr
    );

    modport slave (
        output ReqP, AddrP, ReqN, AddrN, MemAck, MemData,
        input  GntP, GntN, MemCmd, MemAddr, RdData, RdValid, RdSrc, RdErr
    );
endinterface

// File: rtl/mem_read_sequencer_rr_arb2.sv
// Two-way round-robin picker: on contention the side not served last wins.
module rr_arb2 (
    input  logic ReqP,
    input  logic ReqN,
    input  logic LastN,
    output logic PickN
);
    assign PickN = ReqN & (~ReqP | ~LastN);
endmodule

// File: rtl/mem_read_sequencer.sv
// Arbitrates P/N read requests onto the capture-memory command bus, waits for
// the slave acknowledge (or a timeout) and returns the word to the winner.
module mem_read_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    mem_read_sequencer_if.master bus
);
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    seqState_t         stateQ, stateD;
    logic              srcQ, srcD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [7:0]        cntQ, cntD;
    logic              lastNQ, lastND;
    logic              errQ, errD;
    logic [31:0]       rdDataQ, rdDataD;
    logic              rdSrcQ, rdSrcD;
    logic              pickN;
    logic [3:0]        memCmd;
    logic              done;

    rr_arb2 uArb (
        .ReqP  (bus.ReqP),
        .ReqN  (bus.ReqN),
        .LastN (lastNQ),
        .PickN (pickN)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stateQ  <= StIdle;
            srcQ    <= 1'b0;
            addrQ   <= '0;
            cntQ    <= '0;
            lastNQ  <= 1'b1;
            errQ    <= 1'b0;
            rdDataQ <= '0;
            rdSrcQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            srcQ    <= srcD;
            addrQ   <= addrD;
            cntQ    <= cntD;
            lastNQ  <= lastND;
            errQ    <= errD;
            rdDataQ <= rdDataD;
            rdSrcQ  <= rdSrcD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        srcD    = srcQ;
        addrD   = addrQ;
        cntD    = cntQ;
        lastND  = lastNQ;
        errD    = errQ;
        rdDataD = rdDataQ;
        rdSrcD  = rdSrcQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.ReqP || bus.ReqN) begin
                    srcD   = pickN;
                    addrD  = pickN ? bus.AddrN : bus.AddrP;
                    stateD = StIssue;
                end
            end
            StIssue: begin
                cntD   = '0;
                stateD = StWait;
            end
            StWait: begin
                if (bus.MemAck) begin
                    rdDataD = bus.MemData;
                    errD    = 1'b0;
                    rdSrcD  = srcQ;
                    stateD  = StDone;
                end else if (cntQ == CntLast) begin
                    errD   = 1'b1;
                    rdSrcD = srcQ;
                    stateD = StDone;
                end else begin
                    cntD = cntQ + 8'd1;
                end
            end
            StDone: begin
                lastND = srcQ;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output
    // combinationally and an async reset clears the command bus at once.
    always_comb begin
        memCmd = CMD_IDLE;
        unique case (stateQ)
            StIssue: memCmd = srcQ ? CMD_ISSUE_N : CMD_ISSUE_P;
            StWait:  memCmd = srcQ ? CMD_WAIT_N : CMD_WAIT_P;
            default: memCmd = CMD_IDLE;
        endcase
    end

    assign done        = (stateQ == StDone);
    assign bus.MemCmd  = memCmd;
    assign bus.MemAddr = addrQ;
    assign bus.GntP    = done & ~srcQ;
    assign bus.GntN    = done & srcQ;
    assign bus.RdValid = done & ~errQ;
    assign bus.RdErr   = done & errQ;
    assign bus.RdData  = rdDataQ;
    assign bus.RdSrc   = rdSrcQ;
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Self-checking bench for mem_read_sequencer: table of single transactions
// plus hand sequences for reset abort and back-to-back contention.
module tb_mem_read_sequencer;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   pass = 0;
    int   total = 0;

    mem_read_sequencer_if #(.ADDR_W(10)) bus ();

    mem_read_sequencer #(
        .ADDR_W  (10),
        .TIMEOUT (16)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          reqP;
        bit          reqN;
        logic [9:0]  addrP;
        logic [9:0]  addrN;
        int          ackAt;   // first ack cycle, 0 = never
        int          ackLen;
        bit          stray;   // ack during cycles 0 and 1
        logic [31:0] data;
        bit          expN;
        bit          expErr;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    typedef struct {
        bit          isN;
        bit          err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic driveAck(input vec_t v, input int c);
        bit real_ack;
        real_ack = (v.ackAt != 0) && (c >= v.ackAt) && (c < v.ackAt + v.ackLen);
        bus.MemAck  = (v.stray && c <= 1) || real_ack;
        bus.MemData = ((v.ackAt != 0) && (c == v.ackAt)) ? v.data : ~v.data;
    endtask

    function automatic logic [3:0] pulses();
        return {bus.GntP, bus.GntN, bus.RdValid, bus.RdErr};
    endfunction

    task automatic runTxn(input vec_t v);
        exp_t e;
        bit   got;
        int   cyc;
        e = '{v.expN, v.expErr, v.expData, v.expLat};
        sb.push_back(e);
        bus.ReqP  = v.reqP;
        bus.AddrP = v.addrP;
        bus.ReqN  = v.reqN;
        bus.AddrN = v.addrN;
        cyc = 0;
        driveAck(v, cyc);
        got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            driveAck(v, cyc);
            if (cyc == 1) begin
                chk("cmdIssue", 32'(bus.MemCmd), v.expN ? 32'hE : 32'h5);
                chk("memAddr", 32'(bus.MemAddr), 32'(v.expN ? v.addrN : v.addrP));
            end
            if (cyc == 2) chk("cmdWait", 32'(bus.MemCmd), v.expN ? 32'hA : 32'h1);
            if (pulses() != 4'b0000) begin
                got = 1;
                e = sb.pop_front();
                chk("latency", cyc, e.lat);
                chk("gntP", 32'(bus.GntP), 32'(!e.isN));
                chk("gntN", 32'(bus.GntN), 32'(e.isN));
                chk("rdValid", 32'(bus.RdValid), 32'(!e.err));
                chk("rdErr", 32'(bus.RdErr), 32'(e.err));
                chk("rdData", bus.RdData, e.data);
                chk("rdSrc", 32'(bus.RdSrc), 32'(e.isN));
                chk("cmdDone", 32'(bus.MemCmd), 32'h0);
                bus.ReqP = 1'b0;
                bus.ReqN = 1'b0;
            end
        end
        if (!got) begin
            chk("grantTimeout", 32'h0, 32'h1);
            void'(sb.pop_front());
            bus.ReqP = 1'b0;
            bus.ReqN = 1'b0;
        end
        repeat (2) begin
            tick();
            cyc++;
            driveAck(v, cyc);
            chk("noExtraPulse", 32'(pulses()), 32'h0);
        end
        bus.MemAck = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   ackNext;
        int   gnts;

        vecs[0] = '{1, 0, 10'h012, 10'h000, 3, 1, 0, 32'hCAFE0001, 0, 0, 32'hCAFE0001, 4};
        vecs[1] = '{0, 1, 10'h000, 10'h3A5, 2, 1, 0, 32'h12345678, 1, 0, 32'h12345678, 3};
        vecs[2] = '{1, 1, 10'h100, 10'h200, 2, 1, 0, 32'hA5A50003, 0, 0, 32'hA5A50003, 3};
        vecs[3] = '{1, 1, 10'h101, 10'h201, 4, 1, 0, 32'h0BADF00D, 1, 0, 32'h0BADF00D, 5};
        vecs[4] = '{0, 1, 10'h000, 10'h155, 0, 0, 0, 32'hFFFF0000, 1, 1, 32'h0BADF00D, 18};
        vecs[5] = '{1, 0, 10'h2AA, 10'h000, 4, 1, 1, 32'h5555AAAA, 0, 0, 32'h5555AAAA, 5};
        vecs[6] = '{0, 1, 10'h000, 10'h0F0, 2, 3, 0, 32'h77778888, 1, 0, 32'h77778888, 3};
        vecs[7] = '{1, 1, 10'h3FF, 10'h001, 0, 0, 0, 32'h00000001, 0, 1, 32'h77778888, 18};

        bus.ReqP = 0; bus.ReqN = 0; bus.AddrP = '0; bus.AddrN = '0;
        bus.MemAck = 0; bus.MemData = '0;

        repeat (2) @(posedge Clk);
        #1;
        chk("rstCmd", 32'(bus.MemCmd), 32'h0);
        chk("rstPulses", 32'(pulses()), 32'h0);
        chk("rstData", bus.RdData, 32'h0);
        chk("rstSrc", 32'(bus.RdSrc), 32'h0);
        Rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) runTxn(vecs[i]);

        // Reset in the middle of an N read.
        bus.ReqN = 1'b1;
        bus.AddrN = 10'h2F0;
        tick();
        chk("rstSeqIssue", 32'(bus.MemCmd), 32'hE);
        tick();
        tick();
        chk("rstSeqWait", 32'(bus.MemCmd), 32'hA);
        Rst = 1'b1;
        #1;
        chk("rstAsyncCmd", 32'(bus.MemCmd), 32'h0);
        chk("rstAsyncPulses", 32'(pulses()), 32'h0);
        bus.ReqN = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstNoPulse", 32'(pulses()), 32'h0);
        end
        chk("rstClearsData", bus.RdData, 32'h0);

        // Continuous contention: expect P, N, P, N every 4 cycles.
        for (int k = 0; k < 4; k++) begin
            e = '{bit'(k % 2), 1'b0, 32'h10000000 + 32'(k), 4 * k + 3};
            sb.push_back(e);
        end
        bus.ReqP = 1'b1; bus.AddrP = 10'h0AA;
        bus.ReqN = 1'b1; bus.AddrN = 10'h155;
        ackNext = 0;
        gnts = 0;
        for (int c = 1; c <= 40 && gnts < 4; c++) begin
            tick();
            bus.MemAck = ackNext;
            bus.MemData = 32'h10000000 + 32'(gnts);
            ackNext = bus.MemCmd[2];
            if (c % 4 == 1) chk("rrStrobe", 32'(bus.MemCmd), (gnts % 2) ? 32'hE : 32'h5);
            if (pulses() != 4'b0000) begin
                e = sb.pop_front();
                chk("rrGntN", 32'(bus.GntN), 32'(e.isN));
                chk("rrGntP", 32'(bus.GntP), 32'(!e.isN));
                chk("rrValid", 32'(bus.RdValid), 32'h1);
                chk("rrData", bus.RdData, e.data);
                chk("rrCycle", c, e.lat);
                gnts++;
            end
        end
        if (gnts < 4) chk("rrGrants", gnts, 4);
        bus.ReqP = 1'b0;
        bus.ReqN = 1'b0;
        bus.MemAck = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
